// File: rtl/screen_pkg.sv
// Shared constants and types for the text-mode screen writer.
package screen_pkg;

  localparam int unsigned SCR_COLS   = 20;
  localparam int unsigned SCR_ROWS   = 64;
  localparam int unsigned SCR_ADDR_W = 14;

  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_FF    = 8'h0C;

  typedef enum logic {
    IDLE,
    CLEAR
  } writer_state_t;

  function automatic logic is_printable(input logic [7:0] c);
    return (c >= 8'h20) && (c <= 8'h7E);
  endfunction

endpackage

// File: rtl/screen_cursor.sv
// Column/row counter with advance, newline, return, back and home controls.
// Columns wrap into the next row; rows wrap to 0 (no scroll).
module screen_cursor
  import screen_pkg::*;
#(
  parameter int unsigned COLS = SCR_COLS,
  parameter int unsigned ROWS = SCR_ROWS
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       advance,
  input  logic       newline,
  input  logic       ret,
  input  logic       back,
  input  logic       home,
  output logic [7:0] x,
  output logic [5:0] y,
  output logic [7:0] x_next,
  output logic [5:0] y_next,
  output logic       at_origin
);

  localparam logic [7:0] XMax = 8'(COLS - 1);
  localparam logic [5:0] YMax = 6'(ROWS - 1);

  logic [5:0] y_inc;

  // Next position; home has priority, then the text-flow controls.
  always_comb begin
    x_next = x;
    y_next = y;
    y_inc  = (y == YMax) ? 6'd0 : y + 6'd1;
    if (home) begin
      x_next = '0;
      y_next = '0;
    end else if (advance) begin
      if (x == XMax) begin
        x_next = '0;
        y_next = y_inc;
      end else begin
        x_next = x + 8'd1;
      end
    end else if (newline) begin
      x_next = '0;
      y_next = y_inc;
    end else if (ret) begin
      x_next = '0;
    end else if (back) begin
      if (x != 8'd0) begin
        x_next = x - 8'd1;
      end else if (y != 6'd0) begin
        x_next = XMax;
        y_next = y - 6'd1;
      end
    end
  end

  // Position register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x <= '0;
      y <= '0;
    end else begin
      x <= x_next;
      y <= y_next;
    end
  end

  // Used to detect (0,0) for backspace suppression and sweep completion.
  always_comb begin
    at_origin = (x == 8'd0) && (y == 6'd0);
  end

endmodule

// File: rtl/screen_text_writer.sv
// Character-stream writer for the Screen RAM: cursor tracking, control codes
// and a one-cell-per-cycle clear sweep.
module screen_text_writer
  import screen_pkg::*;
#(
  parameter int unsigned COLS = SCR_COLS,
  parameter int unsigned ROWS = SCR_ROWS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [7:0]            in_char,
  input  logic                  clear_req,
  output logic                  wr_en,
  output logic [SCR_ADDR_W-1:0] wr_addr,
  output logic [7:0]            wr_data,
  output logic [7:0]            cursor_x,
  output logic [5:0]            cursor_y,
  output logic                  busy
);

  writer_state_t state_q;

  logic       accept;
  logic       start_clear;
  logic       cur_advance, cur_newline, cur_ret, cur_back, cur_home;
  logic [7:0] cur_x_next;
  logic [5:0] cur_y_next;
  logic       cur_at_origin;

  logic       sw_advance;
  logic [7:0] sw_x, sw_x_next;
  logic [5:0] sw_y, sw_y_next;
  logic       sw_at_origin;
  logic       unused_sweep;

  // Handshake and byte decode into cursor controls.
  always_comb begin
    in_ready    = (state_q == IDLE) && !clear_req;
    accept      = in_valid && in_ready;
    cur_advance = accept && is_printable(in_char);
    cur_newline = accept && (in_char == CH_LF);
    cur_ret     = accept && (in_char == CH_CR);
    cur_back    = accept && (in_char == CH_BS);
    start_clear = (state_q == IDLE) && (clear_req || (accept && (in_char == CH_FF)));
    // Sweep wraps back to (0,0) after its last cell, which marks completion.
    cur_home    = (state_q == CLEAR) && sw_at_origin;
    sw_advance  = start_clear || ((state_q == CLEAR) && !sw_at_origin);
  end

  screen_cursor #(
    .COLS (COLS),
    .ROWS (ROWS)
  ) u_text_cursor (
    .clk       (clk),
    .rst_n     (rst_n),
    .advance   (cur_advance),
    .newline   (cur_newline),
    .ret       (cur_ret),
    .back      (cur_back),
    .home      (cur_home),
    .x         (cursor_x),
    .y         (cursor_y),
    .x_next    (cur_x_next),
    .y_next    (cur_y_next),
    .at_origin (cur_at_origin)
  );

  // Clear sweep counter walks cells in row-major order.
  screen_cursor #(
    .COLS (COLS),
    .ROWS (ROWS)
  ) u_sweep (
    .clk       (clk),
    .rst_n     (rst_n),
    .advance   (sw_advance),
    .newline   (1'b0),
    .ret       (1'b0),
    .back      (1'b0),
    .home      (1'b0),
    .x         (sw_x),
    .y         (sw_y),
    .x_next    (sw_x_next),
    .y_next    (sw_y_next),
    .at_origin (sw_at_origin)
  );

  assign unused_sweep = ^{sw_x_next, sw_y_next};

  // FSM with registered write port and busy flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      busy    <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start_clear) begin
            state_q <= CLEAR;
            busy    <= 1'b1;
            wr_en   <= 1'b1;
            wr_addr <= {sw_y, sw_x};
            wr_data <= CH_SPACE;
          end else if (cur_advance) begin
            wr_en   <= 1'b1;
            wr_addr <= {cursor_y, cursor_x};
            wr_data <= in_char;
          end else if (cur_back && !cur_at_origin) begin
            // Blank the cell the cursor moves back onto.
            wr_en   <= 1'b1;
            wr_addr <= {cur_y_next, cur_x_next};
            wr_data <= CH_SPACE;
          end
        end
        CLEAR: begin
          if (sw_at_origin) begin
            state_q <= IDLE;
            busy    <= 1'b0;
          end else begin
            wr_en   <= 1'b1;
            wr_addr <= {sw_y, sw_x};
            wr_data <= CH_SPACE;
          end
        end
      endcase
    end
  end

endmodule
